branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage consumer of the 32-bit comparator's EQ/GT outputs.
- Decides branch/jump direction and computes the target address.
- Registers a one-cycle PC redirect and drives a multi-cycle wrong-path flush into the fetch and decode registers.
- Holds 32-bit branch and taken-branch performance counters for debug readout.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a taken resolve (1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  an execute-stage instruction is present this cycle.
- stall  in  1  pipeline freeze; when high, all internal state holds.
- br_type  in  3  000 none, 001 BNE, 010 BLT, 011 BEX, 100 J, 101 JAL, 110 JR, 111 reserved (treated as none).
- eq  in  1  comparator EQ0 (A==B).
- gt  in  1  comparator GT0 (A>B).
- pc_plus1  in  32  PC+1 of the execute-stage instruction.
- imm  in  32  sign-extended branch offset.
- jt  in  27  J/JAL target field.
- jr_target  in  32  register value for JR.
- redirect  out  1  take redirect_pc this cycle.
- redirect_pc  out  32  new fetch address.
- flush  out  1  squash fetch/decode contents.
- branch_count  out  CNT_W  resolved branch/jump instructions.
- taken_count  out  CNT_W  resolved instructions that were taken.

Behaviour:
- Reset (reset_n low at a clock edge):
  - redirect=0, redirect_pc=0, flush=0, flush counter=0, branch_count=0, taken_count=0.
  - Reset overrides stall and any in-flight flush.
- Accept condition: in_valid && !stall && !flush && br_type not in {000, 111}.
- Taken evaluation on the accepted cycle (A=rd/rstatus, B=rs/0):
  - BNE: taken = !eq.
  - BLT: taken = !eq && !gt.
  - BEX: taken = !eq.
  - J, JAL, JR: always taken.
- Target computation:
  - BNE and BLT: pc_plus1 + imm, modulo 2^32, carry discarded.
  - J and JAL: {5'b0, jt}.
  - JR: jr_target.
- Latency: the accept is in cycle N; on the edge ending N, a taken result sets redirect=1, loads redirect_pc, and loads the flush counter with FLUSH_CYCLES. A not-taken result leaves redirect=0.
- redirect is a single-cycle pulse. It clears on the first edge at which stall is low. It is held with redirect_pc stable while stall is high.
- flush:
  - flush = (counter != 0).
  - The counter decrements once per non-stalled cycle and saturates at 0.
  - With FLUSH_CYCLES=2 and no stall, flush is high for cycles N+1 and N+2.
- Instructions presented while flush is high are wrong-path:
  - They are neither evaluated nor counted.
  - They cannot trigger a redirect, even if in_valid=1 and the branch is taken.
- Counters:
  - branch_count increments on every accept.
  - taken_count increments on every taken accept.
  - Both wrap modulo 2^CNT_W with no saturation.
- stall high on the accept cycle: no accept occurs; the instruction is re-presented later by the pipeline.
- Back-to-back taken branches in cycles N and N+1: the second is dropped because flush is high in N+1. Only the first redirect occurs.
- Non-taken branches in consecutive cycles: each is accepted and counted; flush stays 0.
- Reset asserted mid-flush or while redirect is held: all state clears on that edge; outputs are 0 on the next cycle.
- There are no combinational paths from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with random inputs -> all outputs 0. Release -> outputs stay 0 until the first accept.
- BNE taken: eq=0, pc_plus1=0x00000010, imm=0xFFFFFFFC -> next cycle redirect=1, redirect_pc=0x0000000C. flush high 2 cycles. branch_count=1, taken_count=1.
- BLT not taken, then BLT taken:
  - eq=0, gt=1 -> redirect stays 0, branch_count=1, taken_count=0.
  - Next cycle eq=0, gt=0, pc_plus1=0xFFFFFFFF, imm=1 -> redirect_pc=0x00000000 (wrap), taken_count=1.
- J with jt=0x7FFFFFF followed immediately by a taken JR (jr_target=0x1234) -> a single redirect to 0x07FFFFFF. The JR is squashed; branch_count=1.
- Stall hold: taken BEX resolved, then stall=1 for 3 cycles -> redirect stays 1 with redirect_pc constant and flush frozen. After stall falls, redirect drops after 1 cycle and flush completes its remaining 2 cycles.
- Reset mid-flush: assert reset_n=0 during the first flush cycle -> flush=0 and both counters=0 on the next cycle. A subsequent taken BNE behaves as on a fresh start.

Source files
------------

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// Execute-stage branch/jump resolution. Consumes the comparator EQ/GT flags,
// decides whether the execute-stage instruction redirects fetch, computes the
// new fetch address, and squashes the wrong-path instructions sitting in the
// fetch and decode registers for FLUSH_CYCLES cycles after a taken resolve.
// Two free-running performance counters record resolved and taken branches.
//
// Ports:
//   clock         system clock, all state updates on the rising edge
//   reset_n       synchronous active-low reset
//   in_valid      an execute-stage instruction is present this cycle
//   stall         pipeline freeze, all internal state holds while high
//   br_type       000 none, 001 BNE, 010 BLT, 011 BEX, 100 J, 101 JAL,
//                 110 JR, 111 reserved (treated as none)
//   eq, gt        comparator A==B and A>B flags
//   pc_plus1      PC+1 of the execute-stage instruction
//   imm           sign-extended branch offset
//   jt            27-bit J/JAL target field
//   jr_target     register value used by JR
//   redirect      registered one-cycle "take redirect_pc" pulse
//   redirect_pc   new fetch address
//   flush         squash fetch/decode contents
//   branch_count  number of resolved branch/jump instructions
//   taken_count   number of resolved instructions that were taken
// -----------------------------------------------------------------------------
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [2:0]       br_type,
  input  logic             eq,
  input  logic             gt,
  input  logic [31:0]      pc_plus1,
  input  logic [31:0]      imm,
  input  logic [26:0]      jt,
  input  logic [31:0]      jr_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b010,
    BR_BEX  = 3'b011,
    BR_J    = 3'b100,
    BR_JAL  = 3'b101,
    BR_JR   = 3'b110,
    BR_RSVD = 3'b111
  } br_type_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  br_type_e   kind;
  logic [2:0] flush_cnt;
  logic       is_branch;
  logic       taken;
  logic [31:0] target;
  logic       accept;

  assign kind = br_type_e'(br_type);

  // Flush is a pure decode of the flush counter register, so it carries no
  // combinational path from the inputs.
  assign flush = (flush_cnt != 3'd0);

  // Classify the instruction, evaluate its direction and compute where fetch
  // should go if it is taken. For BEX the comparator sees A=rstatus, B=0, so
  // "rstatus nonzero" shows up as !eq just like BNE. BLT is taken when A<B,
  // i.e. neither equal nor greater.
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    target    = 32'd0;
    case (kind)
      BR_BNE: begin
        is_branch = 1'b1;
        taken     = !eq;
        target    = pc_plus1 + imm;
      end
      BR_BLT: begin
        is_branch = 1'b1;
        taken     = !eq && !gt;
        target    = pc_plus1 + imm;
      end
      BR_BEX: begin
        is_branch = 1'b1;
        taken     = !eq;
        target    = {5'b0, jt};
      end
      BR_J, BR_JAL: begin
        is_branch = 1'b1;
        taken     = 1'b1;
        target    = {5'b0, jt};
      end
      BR_JR: begin
        is_branch = 1'b1;
        taken     = 1'b1;
        target    = jr_target;
      end
      default: begin
        is_branch = 1'b0;
        taken     = 1'b0;
        target    = 32'd0;
      end
    endcase
  end

  // Anything presented while flush is high is wrong-path and is ignored
  // entirely: not evaluated, not counted, cannot redirect.
  assign accept = in_valid && !stall && !flush && is_branch;

  // All architectural state. Reset wins over stall and any in-flight flush.
  // While stalled everything holds, which keeps a pending redirect and its
  // address stable until the pipeline is free to consume them. A taken
  // accept can only happen with the flush counter already at zero, so
  // loading it never collides with a decrement.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      redirect     <= 1'b0;
      redirect_pc  <= 32'd0;
      flush_cnt    <= 3'd0;
      branch_count <= '0;
      taken_count  <= '0;
    end else if (!stall) begin
      redirect <= accept && taken;
      if (accept && taken) begin
        redirect_pc <= target;
        flush_cnt   <= FLUSH_LOAD;
      end else if (flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end
      if (accept) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (accept && taken) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//
// Self-checking bench for branch_resolve. Every cycle the step task drives
// the inputs, advances an independent behavioural model of the resolver and
// pushes the model's expected post-edge outputs onto a scoreboard queue; the
// DUT outputs sampled just after the edge go onto a second queue. Each test
// task then drains both queues and compares them, adding a few hand-computed
// spot checks for the scenarios with well-known answers.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        stall;
  logic [2:0]  br_type;
  logic        eq;
  logic        gt;
  logic [31:0] pc_plus1;
  logic [31:0] imm;
  logic [26:0] jt;
  logic [31:0] jr_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  typedef struct packed {
    logic        redirect;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] bc;
    logic [31:0] tc;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_redirect;
  logic [31:0] m_pc;
  int          m_cnt;
  logic [31:0] m_bc;
  logic [31:0] m_tc;

  branch_resolve #(
    .FLUSH_CYCLES(2),
    .CNT_W(32)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .stall(stall),
    .br_type(br_type),
    .eq(eq),
    .gt(gt),
    .pc_plus1(pc_plus1),
    .imm(imm),
    .jt(jt),
    .jr_target(jr_target),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .branch_count(branch_count),
    .taken_count(taken_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic string fmt(snap_t s);
    return $sformatf("redirect=%0b pc=%08h flush=%0b bc=%0d tc=%0d",
                     s.redirect, s.pc, s.flush, s.bc, s.tc);
  endfunction

  // Drive one cycle of stimulus, advance the model, record expected and
  // observed outputs for the edge that ends this cycle.
  task automatic step(input logic rst_n, input logic v, input logic st,
                      input logic [2:0] t, input logic e, input logic g,
                      input logic [31:0] p, input logic [31:0] i,
                      input logic [26:0] j, input logic [31:0] r);
    logic        tk;
    logic [31:0] tgt;
    snap_t       s;
    reset_n   = rst_n;
    in_valid  = v;
    stall     = st;
    br_type   = t;
    eq        = e;
    gt        = g;
    pc_plus1  = p;
    imm       = i;
    jt        = j;
    jr_target = r;
    if (!rst_n) begin
      m_redirect = 1'b0;
      m_pc       = 32'd0;
      m_cnt      = 0;
      m_bc       = 32'd0;
      m_tc       = 32'd0;
    end else if (!st) begin
      if (v && m_cnt == 0 && t != 3'd0 && t != 3'd7) begin
        m_bc = m_bc + 32'd1;
        tk   = 1'b1;
        tgt  = 32'd0;
        if (t == 3'd1)      begin tk = !e;       tgt = p + i; end
        else if (t == 3'd2) begin tk = !e && !g; tgt = p + i; end
        else if (t == 3'd3) begin tk = !e;       tgt = {5'b0, j}; end
        else if (t == 3'd6) begin                tgt = r; end
        else                begin                tgt = {5'b0, j}; end
        m_redirect = tk;
        if (tk) begin
          m_tc  = m_tc + 32'd1;
          m_pc  = tgt;
          m_cnt = 2;
        end
      end else begin
        m_redirect = 1'b0;
        if (m_cnt > 0) m_cnt = m_cnt - 1;
      end
    end
    s = '{m_redirect, m_pc, (m_cnt != 0), m_bc, m_tc};
    exp_q.push_back(s);
    @(posedge clock);
    #1;
    s = '{redirect, redirect_pc, flush, branch_count, taken_count};
    obs_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 27'd0, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 27'd0, 32'd0);
  endtask

  // Reset with random inputs, then release and stay idle.
  task automatic test_reset();
    snap_t e, o;
    int    c = 0;
    for (int k = 0; k < 2; k++)
      step(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
           1'($urandom), $urandom, $urandom, 27'($urandom), $urandom);
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL reset cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
    n_cmp++;
    if ({redirect, redirect_pc, flush, branch_count, taken_count} !== 98'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_zero: got %s, want all zero", fmt(o));
    end
  endtask

  // BNE taken with a negative offset, then the two flush cycles drain.
  task automatic test_bne_taken();
    snap_t e, o;
    int    c = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 32'h10, 32'hFFFF_FFFC, 27'd0, 32'd0);
    n_cmp++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h0000_000C || flush !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bne_target: got r=%0b pc=%08h f=%0b, want r=1 pc=0000000c f=1",
               redirect, redirect_pc, flush);
    end
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL bne_taken cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  // BLT not taken, then BLT taken with the target wrapping through zero.
  task automatic test_blt();
    snap_t e, o;
    int    c = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 32'h100, 32'h8, 27'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 27'd0, 32'd0);
    n_cmp++;
    if (redirect !== 1'b1 || redirect_pc !== 32'd0 || taken_count !== 32'd1 ||
        branch_count !== 32'd2) begin
      n_fail++;
      $display("[TB] FAIL blt_wrap: got r=%0b pc=%08h bc=%0d tc=%0d, want r=1 pc=00000000 bc=2 tc=1",
               redirect, redirect_pc, branch_count, taken_count);
    end
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL blt cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  // J immediately followed by a taken JR: the JR is wrong-path.
  task automatic test_back_to_back();
    snap_t e, o;
    int    c = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 32'h0, 32'h0, 27'h7FF_FFFF, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 27'h0, 32'h1234);
    n_cmp++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h07FF_FFFF || branch_count !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL jr_squash: got r=%0b pc=%08h bc=%0d, want r=0 pc=07ffffff bc=1",
               redirect, redirect_pc, branch_count);
    end
    // Consecutive not-taken branches: all counted, no flush.
    idle(2);
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h40, 32'h4, 27'd0, 32'd0);
    // Reserved and none encodings are ignored.
    step(1'b1, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 32'h40, 32'h4, 27'h5, 32'h9);
    step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40, 32'h4, 27'h5, 32'h9);
    n_cmp++;
    if (branch_count !== 32'd4 || taken_count !== 32'd1 || flush !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL not_taken_run: got bc=%0d tc=%0d f=%0b, want bc=4 tc=1 f=0",
               branch_count, taken_count, flush);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  // Taken BEX then a 3-cycle stall: redirect, address and flush freeze.
  task automatic test_stall_hold();
    snap_t e, o;
    int    c = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 32'h0, 32'h0, 27'h0ABC, 32'h0);
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 32'h55, 32'h1, 27'd0, 32'd0);
    n_cmp++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h0000_0ABC || flush !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_hold: got r=%0b pc=%08h f=%0b, want r=1 pc=00000abc f=1",
               redirect, redirect_pc, flush);
    end
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL stall_hold cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  // Reset during the first flush cycle, then a fresh taken BNE.
  task automatic test_reset_mid_flush();
    snap_t e, o;
    int    c = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 32'h0, 32'h0, 27'h333, 32'h0);
    do_reset();
    n_cmp++;
    if ({redirect, redirect_pc, flush, branch_count, taken_count} !== 98'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_flush_reset: got r=%0b pc=%08h f=%0b bc=%0d tc=%0d, want all zero",
               redirect, redirect_pc, flush, branch_count, taken_count);
    end
    step(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 32'h10, 32'h4, 27'd0, 32'd0);
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_flush cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  // Random traffic including stalls on accept cycles and occasional resets.
  task automatic test_random();
    snap_t e, o;
    int    c = 0;
    do_reset();
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 2), 3'($urandom), 1'($urandom), 1'($urandom),
           $urandom, $urandom, 27'($urandom), $urandom);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
      end
      c++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    stall     = 1'b0;
    br_type   = 3'd0;
    eq        = 1'b0;
    gt        = 1'b0;
    pc_plus1  = 32'd0;
    imm       = 32'd0;
    jt        = 27'd0;
    jr_target = 32'd0;
    m_redirect = 1'b0;
    m_pc       = 32'd0;
    m_cnt      = 0;
    m_bc       = 32'd0;
    m_tc       = 32'd0;
    #2;
    test_reset();
    test_bne_taken();
    test_blt();
    test_back_to_back();
    test_stall_hold();
    test_reset_mid_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
